// File: rtl/axi4_lite_reg_pkg.sv
//------------------------------------------------------------------------------
// Module   : axi4_lite_reg_pkg
// Brief    : Shared types, response codes and address decode for the register file.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package axi4_lite_reg_pkg;

    typedef enum logic [1:0] {
        REG_RW,
        REG_RO,
        REG_W1C
    } reg_mode_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Word index of a byte address; byte-offset bits are simply shifted out.
    function automatic logic [31:0] reg_index(input logic [31:0] addr,
                                              input int unsigned byte_shift);
        return addr >> byte_shift;
    endfunction

endpackage

`default_nettype wire

// File: rtl/aix4_lite_if.sv
//------------------------------------------------------------------------------
// Module   : aix4_lite_if
// Brief    : AXI4-Lite bus bundle with master and slave modports.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface aix4_lite_if #(
    parameter int ADDR_BIT_WIDTH = 5,
    parameter int DATA_BIT_WIDTH = 32
);

    logic [ADDR_BIT_WIDTH-1:0]   awaddr;
    logic [2:0]                  awprot;
    logic                        awvalid;
    logic                        awready;
    logic [DATA_BIT_WIDTH-1:0]   wdata;
    logic [DATA_BIT_WIDTH/8-1:0] wstrb;
    logic                        wvalid;
    logic                        wready;
    logic [1:0]                  bresp;
    logic                        bvalid;
    logic                        bready;
    logic [ADDR_BIT_WIDTH-1:0]   araddr;
    logic [2:0]                  arprot;
    logic                        arvalid;
    logic                        arready;
    logic [DATA_BIT_WIDTH-1:0]   rdata;
    logic [1:0]                  rresp;
    logic                        rvalid;
    logic                        rready;

    modport slv_port (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid,    output wready,
        output bresp, bvalid,           input  bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid,    input  rready
    );

    modport mst_port (
        output awaddr, awprot, awvalid, input  awready,
        output wdata, wstrb, wvalid,    input  wready,
        input  bresp, bvalid,           output bready,
        output araddr, arprot, arvalid, input  arready,
        input  rdata, rresp, rvalid,    output rready
    );

endinterface

`default_nettype wire

// File: rtl/axi4_lite_reg_cell.sv
//------------------------------------------------------------------------------
// Module   : axi4_lite_reg_cell
// Brief    : One register with RW / RO / W1C behaviour and a write-commit pulse.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module axi4_lite_reg_cell
    import axi4_lite_reg_pkg::*;
#(
    parameter int                        DATA_BIT_WIDTH = 32,
    parameter reg_mode_t                 MODE           = REG_RW,
    parameter logic [DATA_BIT_WIDTH-1:0] RESET_VAL      = '0
) (
    input  wire logic                        i_clk,
    input  wire logic                        i_sync_rst_n,
    input  wire logic                        i_wr_en,
    input  wire logic [DATA_BIT_WIDTH-1:0]   i_wdata,
    input  wire logic [DATA_BIT_WIDTH/8-1:0] i_wstrb,
    input  wire logic [DATA_BIT_WIDTH-1:0]   i_ro_val,
    input  wire logic [DATA_BIT_WIDTH-1:0]   i_w1c_set,
    output logic      [DATA_BIT_WIDTH-1:0]   o_value,
    output logic                             o_wr_pulse
);

    localparam int c_num_bytes = DATA_BIT_WIDTH / 8;

    logic [DATA_BIT_WIDTH-1:0] r_value;
    logic                      r_wr_pulse;
    logic [DATA_BIT_WIDTH-1:0] w_mask;
    logic [DATA_BIT_WIDTH-1:0] w_clr;
    logic                      w_unused;

    for (genvar b = 0; b < c_num_bytes; b++) begin : g_mask
        assign w_mask[b*8 +: 8] = {8{i_wstrb[b]}};
    end

    assign w_clr    = i_wr_en ? (i_wdata & w_mask) : '0;
    assign w_unused = ^{i_ro_val, i_w1c_set};

    always_ff @(posedge i_clk) begin
        if (!i_sync_rst_n) begin
            r_value    <= RESET_VAL;
            r_wr_pulse <= 1'b0;
        end else begin
            r_wr_pulse <= i_wr_en && (|i_wstrb) && (MODE != REG_RO);
            case (MODE)
                REG_RW: begin
                    if (i_wr_en) begin
                        r_value <= (r_value & ~w_mask) | (i_wdata & w_mask);
                    end
                end
                // OR-ing the set after the clear lets hardware win a same-bit race
                REG_W1C: r_value <= (r_value & ~w_clr) | i_w1c_set;
                default: r_value <= RESET_VAL;
            endcase
        end
    end

    assign o_value    = (MODE == REG_RO) ? i_ro_val : r_value;
    assign o_wr_pulse = r_wr_pulse;

endmodule

`default_nettype wire

// File: rtl/axi4_lite_slv_reg_file.sv
//------------------------------------------------------------------------------
// Module   : axi4_lite_slv_reg_file
// Brief    : AXI4-Lite slave exposing NUM_REGS moded registers to fabric logic.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module axi4_lite_slv_reg_file
    import axi4_lite_reg_pkg::*;
#(
    parameter int                        DATA_BIT_WIDTH = 32,
    parameter int                        NUM_REGS       = 4,
    parameter int                        ADDR_BIT_WIDTH = 5,
    parameter reg_mode_t                 REG_MODES  [NUM_REGS] = '{default: REG_RW},
    parameter logic [DATA_BIT_WIDTH-1:0] RESET_VALS [NUM_REGS] = '{default: '0}
) (
    input  wire logic                                     i_clk,
    input  wire logic                                     i_sync_rst_n,
    aix4_lite_if.slv_port                                 s_axi,
    output logic      [NUM_REGS-1:0][DATA_BIT_WIDTH-1:0]  o_regs,
    input  wire logic [NUM_REGS-1:0][DATA_BIT_WIDTH-1:0]  i_ro_vals,
    input  wire logic [NUM_REGS-1:0][DATA_BIT_WIDTH-1:0]  i_w1c_set,
    output logic      [NUM_REGS-1:0]                      o_wr_pulse
);

    localparam int          c_strb_w     = DATA_BIT_WIDTH / 8;
    localparam int unsigned c_byte_shift = $clog2(c_strb_w);

    logic                      r_ready_en;
    logic                      r_aw_held;
    logic [ADDR_BIT_WIDTH-1:0] r_awaddr;
    logic                      r_w_held;
    logic [DATA_BIT_WIDTH-1:0] r_wdata;
    logic [c_strb_w-1:0]       r_wstrb;
    logic                      r_bvalid;
    logic [1:0]                r_bresp;
    logic                      r_rvalid;
    logic [DATA_BIT_WIDTH-1:0] r_rdata;
    logic [1:0]                r_rresp;

    logic                                    w_awready;
    logic                                    w_wready;
    logic                                    w_arready;
    logic                                    w_commit;
    logic [31:0]                             w_aw_idx;
    logic [31:0]                             w_ar_idx;
    logic                                    w_aw_hit;
    logic                                    w_ar_hit;
    logic [NUM_REGS-1:0]                     w_wr_en;
    logic [NUM_REGS-1:0][DATA_BIT_WIDTH-1:0] w_regs;
    logic [DATA_BIT_WIDTH-1:0]               w_rd_data;
    logic                                    w_unused;

    // r_ready_en keeps every ready low until the first edge after reset release
    assign w_awready = r_ready_en && !r_aw_held && !r_bvalid;
    assign w_wready  = r_ready_en && !r_w_held  && !r_bvalid;
    assign w_arready = r_ready_en && !r_rvalid;
    assign w_commit  = r_aw_held && r_w_held;

    assign w_aw_idx = reg_index(32'(r_awaddr), c_byte_shift);
    assign w_ar_idx = reg_index(32'(s_axi.araddr), c_byte_shift);
    assign w_aw_hit = (w_aw_idx < NUM_REGS);
    assign w_ar_hit = (w_ar_idx < NUM_REGS);
    assign w_unused = ^{s_axi.awprot, s_axi.arprot};

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
        assign w_wr_en[i] = w_commit && (w_aw_idx == 32'(i));

        axi4_lite_reg_cell #(
            .DATA_BIT_WIDTH (DATA_BIT_WIDTH),
            .MODE           (REG_MODES[i]),
            .RESET_VAL      (RESET_VALS[i])
        ) u_cell (
            .i_clk        (i_clk),
            .i_sync_rst_n (i_sync_rst_n),
            .i_wr_en      (w_wr_en[i]),
            .i_wdata      (r_wdata),
            .i_wstrb      (r_wstrb),
            .i_ro_val     (i_ro_vals[i]),
            .i_w1c_set    (i_w1c_set[i]),
            .o_value      (w_regs[i]),
            .o_wr_pulse   (o_wr_pulse[i])
        );
    end

    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_ar_idx == 32'(i)) begin
                w_rd_data = w_regs[i];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_sync_rst_n) begin
            r_ready_en <= 1'b0;
            r_aw_held  <= 1'b0;
            r_awaddr   <= '0;
            r_w_held   <= 1'b0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= RESP_OKAY;
        end else begin
            r_ready_en <= 1'b1;

            if (s_axi.awvalid && w_awready) begin
                r_aw_held <= 1'b1;
                r_awaddr  <= s_axi.awaddr;
            end
            if (s_axi.wvalid && w_wready) begin
                r_w_held <= 1'b1;
                r_wdata  <= s_axi.wdata;
                r_wstrb  <= s_axi.wstrb;
            end

            // Readys are low while both are held, so no new capture races the clear
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_aw_hit ? RESP_OKAY : RESP_SLVERR;
            end else if (r_bvalid && s_axi.bready) begin
                r_bvalid <= 1'b0;
            end

            if (s_axi.arvalid && w_arready) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_ar_hit ? w_rd_data : '0;
                r_rresp  <= w_ar_hit ? RESP_OKAY : RESP_SLVERR;
            end else if (r_rvalid && s_axi.rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    assign s_axi.awready = w_awready;
    assign s_axi.wready  = w_wready;
    assign s_axi.bvalid  = r_bvalid;
    assign s_axi.bresp   = r_bresp;
    assign s_axi.arready = w_arready;
    assign s_axi.rvalid  = r_rvalid;
    assign s_axi.rdata   = r_rdata;
    assign s_axi.rresp   = r_rresp;
    assign o_regs        = w_regs;

endmodule

`default_nettype wire
